// File: rtl/if_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : if_stage_pkg                                                |
// | Purpose  : Shared widths, default reset/bubble values, next-PC select  |
// |            encoding and word-alignment helper for the fetch stage.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package if_stage_pkg;

  localparam int          c_ADDR_W        = 32;
  localparam int          c_INSTR_W       = 32;
  localparam logic [31:0] c_RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] c_NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

  // Source of the next PC value.
  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_PC4    = 2'd1,
    SEL_TARGET = 2'd2
  } pc_sel_e;

  // Instruction addresses are word aligned; drop any low-order garbage.
  function automatic logic [c_ADDR_W-1:0] word_align(input logic [c_ADDR_W-1:0] a);
    return {a[c_ADDR_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : if_id_reg                                                   |
// | Purpose  : Stage register (instruction, PC+4, valid) with stall, flush |
// |            and bubble controls. Priority: rst > stall > flush|bubble.  |
// | Ports    : clk, rst        - clock, sync active-high reset             |
// |            i_stall         - hold all fields                           |
// |            i_flush         - squash to bubble (redirect)               |
// |            i_bubble        - insert bubble (no valid fetch)            |
// |            i_instr/i_pcplus4 - incoming fields                         |
// |            o_instr/o_pcplus4/o_valid - registered fields               |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module if_id_reg #(
  parameter int          INSTR_W   = 32,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_bubble,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pcplus4,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pcplus4,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pcplus4;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (rst || (!i_stall && (i_flush || i_bubble))) begin
      r_instr   <= NOP_INSTR[INSTR_W-1:0];
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else if (!i_stall) begin
      r_instr   <= i_instr;
      r_pcplus4 <= i_pcplus4;
      r_valid   <= 1'b1;
    end
  end

  assign o_instr   = r_instr;
  assign o_pcplus4 = r_pcplus4;
  assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : if_stage                                                    |
// | Purpose  : MIPS instruction-fetch stage: PC register, PC+4, next-PC    |
// |            select (jump > branch > PC+4) and the IF/ID register.       |
// | Ports    : clk, rst            - clock, sync active-high reset         |
// |            StallF, StallD      - hazard holds for PC and IF/ID         |
// |            PCSrcD, PCBranchD   - taken branch and its target           |
// |            JumpD, JumpTarget   - J/JAL/JR and its target               |
// |            ImemAddr            - instruction address (= PCF)           |
// |            ImemRdata, ImemReady - instruction word / valid this cycle  |
// |            InstructionD, PCPlus4D, ValidD - IF/ID outputs              |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 PCSrcD,
  input  logic [c_ADDR_W-1:0]  PCBranchD,
  input  logic                 JumpD,
  input  logic [c_ADDR_W-1:0]  JumpTarget,
  output logic [c_ADDR_W-1:0]  ImemAddr,
  input  logic [c_INSTR_W-1:0] ImemRdata,
  input  logic                 ImemReady,
  output logic [c_INSTR_W-1:0] InstructionD,
  output logic [c_ADDR_W-1:0]  PCPlus4D,
  output logic                 ValidD
);

  logic [c_ADDR_W-1:0] r_pcf;
  logic [c_ADDR_W-1:0] w_pcplus4f;
  logic [c_ADDR_W-1:0] w_target;
  logic [c_ADDR_W-1:0] w_pc_next;
  logic                w_redirect;
  pc_sel_e             w_sel;

  // Natural 32-bit wrap: FFFF_FFFC + 4 = 0.
  assign w_pcplus4f = r_pcf + 32'd4;
  assign w_redirect = JumpD | PCSrcD;
  assign w_target   = word_align(JumpD ? JumpTarget : PCBranchD);

  // A redirect wins over an outstanding wait state: the pending fetch is
  // simply abandoned. During StallF the redirect is dropped because ID is
  // also held and will present it again.
  always_comb begin
    w_sel = SEL_HOLD;
    if (StallF)          w_sel = SEL_HOLD;
    else if (w_redirect) w_sel = SEL_TARGET;
    else if (ImemReady)  w_sel = SEL_PC4;
  end

  always_comb begin
    w_pc_next = r_pcf;
    case (w_sel)
      SEL_PC4:    w_pc_next = w_pcplus4f;
      SEL_TARGET: w_pc_next = w_target;
      default:    w_pc_next = r_pcf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_pcf <= RESET_PC;
    else     r_pcf <= w_pc_next;
  end

  assign ImemAddr = r_pcf;

  if_id_reg #(
    .INSTR_W   (c_INSTR_W),
    .ADDR_W    (c_ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (StallD),
    .i_flush   (w_redirect & ~StallF),
    .i_bubble  (~ImemReady | StallF),
    .i_instr   (ImemRdata),
    .i_pcplus4 (w_pcplus4f),
    .o_instr   (InstructionD),
    .o_pcplus4 (PCPlus4D),
    .o_valid   (ValidD)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_if_stage                                                 |
// | Purpose  : Directed vector bench for if_stage. Instruction memory is a |
// |            pure function of the address so expected words are known.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, PCSrcD, JumpD, ImemReady;
  logic [31:0] PCBranchD, JumpTarget, ImemAddr, ImemRdata, InstructionD, PCPlus4D;
  logic        ValidD;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] wmem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  assign ImemRdata = wmem(ImemAddr);

  if_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .JumpTarget(JumpTarget),
    .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .ImemReady(ImemReady),
    .InstructionD(InstructionD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  typedef struct {
    logic        rst, sf, sd, pcsrc, jump, ready;
    logic [31:0] pb, jt;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic sf, input logic sd,
                              input logic pcsrc, input logic [31:0] pb,
                              input logic jump, input logic [31:0] jt,
                              input logic ready, input logic [31:0] e_addr,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid);
    vec_t v;
    v.rst = r; v.sf = sf; v.sd = sd; v.pcsrc = pcsrc; v.pb = pb;
    v.jump = jump; v.jt = jt; v.ready = ready;
    v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic check32(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; StallF = v.sf; StallD = v.sd; PCSrcD = v.pcsrc;
    PCBranchD = v.pb; JumpD = v.jump; JumpTarget = v.jt; ImemReady = v.ready;
  endtask

  task automatic check_all(input int idx, input vec_t v);
    check32("addr",  idx, ImemAddr, v.e_addr);
    check32("instr", idx, InstructionD, v.e_instr);
    check32("pc4",   idx, PCPlus4D, v.e_pc4);
    check32("valid", idx, {31'd0, ValidD}, {31'd0, v.e_valid});
  endtask

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    vec_t hv;
    //            rst sf sd br pb        j  jt            rdy  addr          instr                pc4       v
    // reset
    vq.push_back(mk(1, 0, 0, 0, 0,        0, 0,            1, 32'h0,         NOP,                 0,        0));
    // sequential fetch
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h4,         wmem(32'h0),         32'h4,    1));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h8,         wmem(32'h4),         32'h8,    1));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'hC,         wmem(32'h8),         32'hC,    1));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h10,        wmem(32'hC),         32'h10,   1));
    // taken branch at 0x10 -> 0x40, one bubble
    vq.push_back(mk(0, 0, 0, 1, 32'h40,   0, 0,            1, 32'h40,        NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h44,        wmem(32'h40),        32'h44,   1));
    // jump beats branch; misaligned jump target forced aligned
    vq.push_back(mk(0, 0, 0, 1, 32'h80,   1, 32'h100,      1, 32'h100,       NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        1, 32'h103,      1, 32'h100,       NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h104,       wmem(32'h100),       32'h104,  1));
    // full stall with redirect pending: all held, then redirect taken
    vq.push_back(mk(0, 1, 1, 1, 32'h200,  0, 0,            1, 32'h104,       wmem(32'h100),       32'h104,  1));
    vq.push_back(mk(0, 1, 1, 1, 32'h200,  0, 0,            1, 32'h104,       wmem(32'h100),       32'h104,  1));
    vq.push_back(mk(0, 0, 0, 1, 32'h200,  0, 0,            1, 32'h200,       NOP,                 0,        0));
    // wait states at 0x20
    vq.push_back(mk(0, 0, 0, 0, 0,        1, 32'h20,       1, 32'h20,        NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0, 32'h20,        NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0, 32'h20,        NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0, 32'h20,        NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h24,        wmem(32'h20),        32'h24,   1));
    // StallF only: PC holds, ID bubbles, redirect dropped
    vq.push_back(mk(0, 1, 0, 0, 0,        0, 0,            1, 32'h24,        NOP,                 0,        0));
    vq.push_back(mk(0, 1, 0, 1, 32'h300,  0, 0,            1, 32'h24,        NOP,                 0,        0));
    // redirect taken while imem not ready
    vq.push_back(mk(0, 0, 0, 1, 32'h300,  0, 0,            0, 32'h300,       NOP,                 0,        0));
    // wrap at top of address space
    vq.push_back(mk(0, 0, 0, 0, 0,        1, 32'hFFFF_FFFC,1, 32'hFFFF_FFFC, NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h0,         wmem(32'hFFFF_FFFC), 32'h0,    1));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h4,         wmem(32'h0),         32'h4,    1));
    // reset during a wait state
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0, 32'h4,         NOP,                 0,        0));
    vq.push_back(mk(1, 0, 0, 0, 0,        0, 0,            0, 32'h0,         NOP,                 0,        0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 0,            1, 32'h4,         wmem(32'h0),         32'h4,    1));

    drive(vq[0]);
    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk); #1;
      check_all(i, vq[i]);
    end

    // Hand-written: reset overrides a simultaneous stall and redirect.
    // Move to 0x8 with a valid word in ID first.
    hv = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8, wmem(32'h4), 32'h8, 1);
    drive(hv);
    @(posedge clk); #1;
    check_all(100, hv);
    hv = mk(1, 1, 1, 1, 32'h500, 1, 32'h600, 0, 32'h0, NOP, 0, 0);
    drive(hv);
    @(posedge clk); #1;
    check_all(101, hv);
    // No residual state: clean restart from RESET_PC.
    hv = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h4, wmem(32'h0), 32'h4, 1);
    drive(hv);
    @(posedge clk); #1;
    check_all(102, hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
